// File: rtl/ma_pkg.sv
// Shared definitions for the moving-average family (averager, sum decoder,
// future decimator): default geometry, sum-width derivation, saturation
// helper and the common run/fault state type.
package ma_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned N_DEF  = 8;

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    // Width of a full-precision running sum of n samples of dw bits.
    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n);
        return dw + $clog2(n);
    endfunction

    // Clamp a signed value to the dw-bit signed range; caller keeps the low dw bits.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] r, input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/ma_hist_ring.sv
// N x DW circular history buffer. rd_data always presents the entry at the
// write pointer, i.e. the oldest stored sample, which is overwritten on the
// next write. N must be a power of two so the pointer wraps naturally.
module ma_hist_ring #(
    parameter int unsigned DW = 16,
    parameter int unsigned N  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned PW = $clog2(N);

    logic [DW-1:0] mem [N];
    logic [PW-1:0] wr_ptr;

    assign rd_data = mem[wr_ptr];

    // Write at the pointer and advance; clear returns to the all-zero history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
        end else if (clr) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/ma_sum_decoder.sv
// Moving-average sum decoder: recovers x[n] = S[n] - S[n-1] + x[n-N] from the
// running-sum stream, with saturation, sticky overflow flag and optional halt.
// Optional feature macro: MA_SUM_DECODER_ERR_CNT_EN adds the err_cnt port.
module ma_sum_decoder
    import ma_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned N           = N_DEF,
    parameter bit          HALT_ON_ERR = 1'b0,
    localparam int unsigned SW         = sum_width(DW, N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [SW-1:0] in_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 err_ovf
`ifdef MA_SUM_DECODER_ERR_CNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    state_t                state;
    logic signed [SW-1:0]  prev_sum;
    logic [DW-1:0]         oldest;
    logic signed [SW:0]    r;
    logic signed [63:0]    r64;
    logic signed [63:0]    sat64;
    logic signed [DW-1:0]  sat_val;
    logic                  ovf;
    logic                  accept;

    // Stall on fault, on a full unaccepted output, and during a restart.
    assign in_ready = (state == RUN) && (!out_valid || out_ready) && !sync_clr;
    assign accept   = in_valid && in_ready;

    // Reconstruct the sample at SW+1 bits, then saturate to DW bits.
    always_comb begin
        r       = (SW+1)'(in_sum) - (SW+1)'(prev_sum) + (SW+1)'($signed(oldest));
        r64     = 64'(r);
        sat64   = sat_dw(r64, DW);
        sat_val = sat64[DW-1:0];
        ovf     = (sat64 != r64);
    end

    ma_hist_ring #(
        .DW (DW),
        .N  (N)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clr     (sync_clr),
        .wr_en   (accept),
        .wr_data (sat_val),
        .rd_data (oldest)
    );

    // Output register, previous sum, sticky flag and run/fault state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            prev_sum  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_ovf   <= 1'b0;
        end else if (sync_clr) begin
            state     <= RUN;
            prev_sum  <= '0;
            out_valid <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (accept) begin
            prev_sum  <= in_sum;
            out_data  <= sat_val;
            out_valid <= 1'b1;
            if (ovf) begin
                err_ovf <= 1'b1;
                if (HALT_ON_ERR) begin
                    state <= FAULT;
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MA_SUM_DECODER_ERR_CNT_EN
    // Count saturated accepts, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (sync_clr) begin
            err_cnt <= '0;
        end else if (accept && ovf && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ma_sum_decoder.sv
// Self-checking bench for ma_sum_decoder (HALT_ON_ERR=1): directed cases with
// literal expectations followed by randomized traffic against a queue model.
module tb_ma_sum_decoder;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int SW = 19;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 sync_clr  = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [SW-1:0] in_sum    = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 err_ovf;
`ifdef MA_SUM_DECODER_ERR_CNT_EN
    logic [15:0]          err_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: last N recovered samples as a queue, oldest at front.
    bit     m_valid = 1'b0;
    bit     m_err   = 1'b0;
    bit     m_fault = 1'b0;
    longint m_data  = 0;
    longint m_prev  = 0;
    longint m_cnt   = 0;
    longint hq[$];

    always #5 clk = ~clk;

    ma_sum_decoder #(
        .DW          (DW),
        .N           (N),
        .HALT_ON_ERR (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_ovf   (err_ovf)
`ifdef MA_SUM_DECODER_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_fault && (!m_valid || out_ready) && !sync_clr;
    endfunction

    function automatic void m_clear();
        hq.delete();
        repeat (N) hq.push_back(0);
        m_prev  = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fault = 1'b0;
        m_cnt   = 0;
    endfunction

    // Model update on the same edges as the design.
    always @(posedge clk or posedge reset) begin
        longint r;
        longint s;
        if (reset) begin
            m_clear();
            m_data = 0;
        end else if (sync_clr) begin
            m_clear();
        end else if (in_valid && m_ready()) begin
            r = longint'(in_sum) - m_prev + hq[0];
            s = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
            void'(hq.pop_front());
            hq.push_back(s);
            m_prev  = longint'(in_sum);
            m_data  = s;
            m_valid = 1'b1;
            if (s != r) begin
                m_err   = 1'b1;
                m_fault = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", longint'(in_ready), longint'(m_ready()));
        chk("out_valid", longint'(out_valid), longint'(m_valid));
        chk("out_data", longint'(out_data), m_data);
        chk("err_ovf", longint'(err_ovf), longint'(m_err));
`ifdef MA_SUM_DECODER_ERR_CNT_EN
        chk("err_cnt", longint'(err_cnt), m_cnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sum (in_valid stays high) and check the registered result.
    task automatic send(input longint s, input longint exp, input string nm);
        in_valid = 1'b1;
        in_sum   = SW'(s);
        tick();
        chk(nm, longint'(out_data), exp);
        chk({nm, "_valid"}, longint'(out_valid), 1);
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        in_valid = 1'b1;
        in_sum   = SW'(12345);
        tick();
        sync_clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", longint'(out_valid), 0);
        chk("clr_err", longint'(err_ovf), 0);
    endtask

    initial begin
        longint v;

        repeat (3) tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_err", longint'(err_ovf), 0);
        #2 reset = 1'b0;
        tick();

        // Constant stream of x=100.
        for (int i = 0; i < 10; i++) begin
            send((i < 8) ? 100 * (i + 1) : 800, 100, "const");
        end
        in_valid = 1'b0;
        tick();
        chk("const_err", longint'(err_ovf), 0);
        clr();

        // Impulse: cancellation of x[n-8] at wrap-around.
        for (int i = 0; i < 16; i++) begin
            send((i < 8) ? 1000 : 0, (i == 0) ? 1000 : 0, "impulse");
        end
        in_valid = 1'b0;
        clr();

        // Backpressure: out_ready 1,0,0,1 with in_valid held.
        send(10, 10, "bp0");
        out_ready = 1'b0;
        in_sum    = SW'(30);
        #1 chk("bp_ready_lo", longint'(in_ready), 0);
        tick();
        chk("bp_hold1", longint'(out_data), 10);
        chk("bp_hold1_valid", longint'(out_valid), 1);
        tick();
        chk("bp_hold2", longint'(out_data), 10);
        out_ready = 1'b1;
        #1 chk("bp_ready_hi", longint'(in_ready), 1);
        tick();
        chk("bp1", longint'(out_data), 20);
        send(60, 30, "bp2");
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", longint'(out_valid), 0);
        chk("bp_drain_data", longint'(out_data), 30);
        clr();

        // Positive overflow, halt, restart.
        send(0, 0, "ovf0");
        send(40000, 32767, "ovf_pos");
        chk("ovf_err", longint'(err_ovf), 1);
        in_sum = SW'(100);
        for (int i = 0; i < 3; i++) begin
            #1 chk("halt_ready", longint'(in_ready), 0);
            tick();
        end
        chk("halt_hold", longint'(out_data), 32767);
`ifdef MA_SUM_DECODER_ERR_CNT_EN
        chk("err_cnt_one", longint'(err_cnt), 1);
`endif
        clr();
        send(100, 100, "after_clr");
        in_valid = 1'b0;
        tick();
        clr();

        // Negative bound.
        send(-40000, -32768, "ovf_neg");
        chk("ovf_neg_err", longint'(err_ovf), 1);
        in_valid = 1'b0;
        tick();
        clr();

        // Asynchronous reset during the 4th sample.
        send(100, 100, "rst_s1");
        send(200, 100, "rst_s2");
        send(300, 100, "rst_s3");
        in_sum = SW'(400);
        #2 reset = 1'b1;
        #1 chk("async_rst_valid", longint'(out_valid), 0);
        chk("async_rst_data", longint'(out_data), 0);
        in_valid = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        tick();
        send(100, 100, "rst_r1");
        send(200, 100, "rst_r2");
        in_valid = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            sync_clr  = ($urandom % 48) == 0;
            if (($urandom % 10) == 0) begin
                v = longint'($urandom_range(300000, 0)) - 150000;
            end else begin
                v = longint'($urandom_range(8000, 0)) - 4000;
            end
            in_sum = SW'(v);
            tick();
        end
        in_valid  = 1'b0;
        sync_clr  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
